// File: rtl/control_sequencer_if.sv
// Control sequencer bus: command inputs, decoder opcode, and the strobe/status
// outputs fed back to the datapath.
interface control_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             clear;
  logic             stall;
  logic [6:0]       OPCODE;
  logic             pc_en;
  logic             ir_load;
  logic             alu_en;
  logic             rf_wr_en;
  logic             wr_sel;
  logic             busy;
  logic             halted;
  logic             illegal_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  // Controller / stimulus side
  modport master (
    output start, clear, stall, OPCODE,
    input  pc_en, ir_load, alu_en, rf_wr_en, wr_sel,
    input  busy, halted, illegal_op, state, instr_count
  );

  // Sequencer side
  modport slave (
    input  start, clear, stall, OPCODE,
    output pc_en, ir_load, alu_en, rf_wr_en, wr_sel,
    output busy, halted, illegal_op, state, instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with stall freeze, sticky HALT/ERROR, and a saturating retire counter.
module control_sequencer #(
  parameter int CNT_W     = 16,
  parameter int MAX_INSTR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  control_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             wr_sel_q, wr_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_retire;

  // Retire limit hit on this writeback (compared before saturation)
  assign last_retire = (MAX_INSTR != 0) &&
                       ((32'(cnt_q) + 32'd1) == 32'(MAX_INSTR));

  // State, write-select and counter registers; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_sel_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_sel_q <= wr_sel_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, opcode classification and retire counting; stall holds everything
  always_comb begin
    state_d  = state_q;
    wr_sel_d = wr_sel_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_FETCH;
      S_FETCH:   if (!bus.stall) state_d = S_DECODE;
      S_DECODE:
        if (!bus.stall) begin
          case (bus.OPCODE)
            7'b0110011,
            7'b0010011: begin wr_sel_d = 1'b0; state_d = S_EXECUTE; end
            7'b0110111: begin wr_sel_d = 1'b1; state_d = S_EXECUTE; end
            7'b1110011: state_d = S_HALT;
            default:    state_d = S_ERROR;
          endcase
        end
      S_EXECUTE: if (!bus.stall) state_d = S_WRITEBACK;
      S_WRITEBACK:
        if (!bus.stall) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          state_d = last_retire ? S_HALT : S_FETCH;
        end
      S_HALT, S_ERROR:
        if (bus.clear) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      default:   state_d = S_ERROR;
    endcase
  end

  // Strobes decode from the state register, gated off while stalled
  assign bus.ir_load    = (state_q == S_FETCH)     && !bus.stall;
  assign bus.alu_en     = (state_q == S_EXECUTE)   && !bus.stall;
  assign bus.rf_wr_en   = (state_q == S_WRITEBACK) && !bus.stall;
  assign bus.pc_en      = (state_q == S_WRITEBACK) && !bus.stall;
  assign bus.wr_sel     = wr_sel_q;
  assign bus.busy       = (state_q == S_FETCH)   || (state_q == S_DECODE) ||
                          (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign bus.halted     = (state_q == S_HALT);
  assign bus.illegal_op = (state_q == S_ERROR);
  assign bus.state      = state_q;
  assign bus.instr_count = cnt_q;

endmodule
